csr_file: RTL and testbench

Parametrised machine-mode CSR file, successor to the single-configuration CSR unit. It provides configurable-width cycle/instret counters, `HPM_COUNTERS` event-driven hardware performance counters with `mcountinhibit`, and vectored `mtvec`. It adds `mtval` capture, registered interrupt arbitration from external interrupt lines, and `trap_vector`/`mret_vector` outputs. It sits between decode (read port), writeback (write port, trap/mret events) and fetch (redirect vectors).

---
 rtl/csr_pkg.sv | 44 ++++
 rtl/csr_counter.sv | 39 +++
 rtl/csr_file.sv | 243 ++++++++++++++++++++++++
 tb/tb_csr_file.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, interrupt codes and field encodings
// for the machine-mode CSR file.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    DIRECT   = 2'b00,
    VECTORED = 2'b01
  } mtvec_mode_e;

endpackage

// File: rtl/csr_counter.sv
// One configurable-width counter with split 32-bit halves;
// a write to either half wins over the increment.
module csr_counter #(
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     inhibit,
  input  logic                     wr_lo,
  input  logic                     wr_hi,
  input  logic [31:0]              data,
  output logic [COUNTER_WIDTH-1:0] count
);
  import csr_pkg::*;

  localparam logic [COUNTER_WIDTH-1:0] ONE = 1;

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo) begin
      cnt_d[31:0] = data;
    end else if (wr_hi) begin
      cnt_d[COUNTER_WIDTH-1:32] = data[COUNTER_WIDTH-33:0];
    end else if (inc && !inhibit) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: counters, trap state, mtvec and
// registered interrupt arbitration.
module csr_file #(
  parameter int          HPM_COUNTERS  = 4,
  parameter int          COUNTER_WIDTH = 64,
  parameter bit          VECTORED      = 1'b1,
  parameter logic [31:0] MTVEC_RESET   = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [11:0]             read_address,
  output logic [31:0]             read_data,
  output logic                    readable,
  output logic                    writeable,
  input  logic                    write_enable,
  input  logic [11:0]             write_address,
  input  logic [31:0]             write_data,
  input  logic                    retired,
  input  logic                    traped,
  input  logic                    mret,
  input  logic [31:0]             ecp,
  input  logic [3:0]              trap_cause,
  input  logic                    interupt,
  input  logic [31:0]             trap_value,
  input  logic                    irq_external,
  input  logic                    irq_timer,
  input  logic                    irq_software,
  input  logic [HPM_COUNTERS-1:0] hpm_event,
  output logic                    interrupt_pending,
  output logic [3:0]              interrupt_cause,
  output logic [31:0]             trap_vector,
  output logic [31:0]             mret_vector
);
  import csr_pkg::*;

  localparam logic [31:0] INH_MASK =
    32'h5 | (32'((64'h1 << HPM_COUNTERS) - 64'h1) << 3);

  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic [2:0]  mie_q, mie_d;
  logic [2:0]  mip_q, mip_d;
  logic [31:0] inhibit_q, inhibit_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [29:0] tvec_base_q, tvec_base_d;
  mtvec_mode_e tvec_mode_q, tvec_mode_d;
  logic        irq_pend_q, irq_pend_d;
  logic [3:0]  irq_cause_q, irq_cause_d;
  logic [2:0]  pend;
  logic [31:0] mepc_rd;

  logic [COUNTER_WIDTH-1:0] cnt [32];
  logic                     cnt_wr;

  // Counter CSRs share a 32-slot index space: 0=cycle, 2=instret, 3+=hpm
  assign cnt_wr = write_enable
               && write_address[11:8] == 4'hB
               && write_address[6:5] == 2'b00;

  for (genvar g = 0; g < 32; g++) begin : g_cnt
    if (g == 0 || g == 2 || (g >= 3 && g < 3 + HPM_COUNTERS)) begin : g_on
      logic inc;
      if (g == 0) begin : g_cy
        assign inc = 1'b1;
      end else if (g == 2) begin : g_ir
        assign inc = retired;
      end else begin : g_hpm
        assign inc = hpm_event[g-3];
      end
      csr_counter #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
      ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (inc),
        .inhibit(inhibit_q[g]),
        .wr_lo  (cnt_wr && !write_address[7]
                 && write_address[4:0] == 5'(g)),
        .wr_hi  (cnt_wr && write_address[7]
                 && write_address[4:0] == 5'(g)),
        .data   (write_data),
        .count  (cnt[g])
      );
    end else begin : g_off
      assign cnt[g] = '0;
    end
  end

  assign mepc_rd = mepc_q & 32'hFFFF_FFFC;

  always_comb begin
    mst_mie_d   = mst_mie_q;
    mst_mpie_d  = mst_mpie_q;
    mie_d       = mie_q;
    mip_d       = {irq_external, irq_timer, irq_software};
    inhibit_d   = inhibit_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    tvec_base_d = tvec_base_q;
    tvec_mode_d = tvec_mode_q;
    if (traped) begin
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      mepc_d     = ecp;
      mcause_d   = {interupt, 27'b0, trap_cause};
      mtval_d    = trap_value;
    end else if (mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
    // CSR writes come last so they override trap/mret effects
    if (write_enable) begin
      case (write_address)
        CSR_MSTATUS: begin
          mst_mie_d  = write_data[MSTATUS_MIE];
          mst_mpie_d = write_data[MSTATUS_MPIE];
        end
        CSR_MIE: mie_d = {write_data[IRQ_MEI],
                          write_data[IRQ_MTI],
                          write_data[IRQ_MSI]};
        CSR_MTVEC: begin
          tvec_base_d = write_data[31:2];
          tvec_mode_d = (VECTORED && write_data[1:0] == 2'b01)
                      ? csr_pkg::VECTORED : DIRECT;
        end
        CSR_MCOUNTINHIBIT: inhibit_d = write_data & INH_MASK;
        CSR_MSCRATCH: mscratch_d = write_data;
        CSR_MEPC:     mepc_d     = write_data;
        CSR_MCAUSE:   mcause_d   = write_data;
        CSR_MTVAL:    mtval_d    = write_data;
        default: ;
      endcase
    end
  end

  // pend bits: [2]=MEI [1]=MTI [0]=MSI
  assign pend = mie_q & mip_q & {3{mst_mie_q}};

  always_comb begin
    irq_pend_d  = |pend;
    irq_cause_d = irq_cause_q;
    if (pend[2])      irq_cause_d = IRQ_MEI;
    else if (pend[0]) irq_cause_d = IRQ_MSI;
    else if (pend[1]) irq_cause_d = IRQ_MTI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mst_mie_q   <= 1'b0;
      mst_mpie_q  <= 1'b0;
      mie_q       <= '0;
      mip_q       <= '0;
      inhibit_q   <= '0;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      tvec_base_q <= MTVEC_RESET[31:2];
      tvec_mode_q <= DIRECT;
      irq_pend_q  <= 1'b0;
      irq_cause_q <= '0;
    end else begin
      mst_mie_q   <= mst_mie_d;
      mst_mpie_q  <= mst_mpie_d;
      mie_q       <= mie_d;
      mip_q       <= mip_d;
      inhibit_q   <= inhibit_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      tvec_base_q <= tvec_base_d;
      tvec_mode_q <= tvec_mode_d;
      irq_pend_q  <= irq_pend_d;
      irq_cause_q <= irq_cause_d;
    end
  end

  logic        is_cnt;
  logic [63:0] cnt_sel;

  assign is_cnt = (read_address[11:8] == 4'hB
                || read_address[11:8] == 4'hC)
               && read_address[6:5] == 2'b00
               && read_address[4:0] != 5'd1;
  assign cnt_sel = 64'(cnt[read_address[4:0]]);

  always_comb begin
    read_data = '0;
    readable  = 1'b1;
    writeable = 1'b1;
    unique case (1'b1)
      read_address == CSR_MSTATUS: begin
        read_data               = 32'h0000_1800;
        read_data[MSTATUS_MIE]  = mst_mie_q;
        read_data[MSTATUS_MPIE] = mst_mpie_q;
      end
      read_address == CSR_MISA: read_data = MISA_VALUE;
      read_address == CSR_MIE: begin
        read_data[IRQ_MEI] = mie_q[2];
        read_data[IRQ_MTI] = mie_q[1];
        read_data[IRQ_MSI] = mie_q[0];
      end
      read_address == CSR_MIP: begin
        read_data[IRQ_MEI] = mip_q[2];
        read_data[IRQ_MTI] = mip_q[1];
        read_data[IRQ_MSI] = mip_q[0];
      end
      read_address == CSR_MTVEC:
        read_data = {tvec_base_q, tvec_mode_q};
      read_address == CSR_MCOUNTINHIBIT: read_data = inhibit_q;
      read_address == CSR_MSCRATCH: read_data = mscratch_q;
      read_address == CSR_MEPC:     read_data = mepc_rd;
      read_address == CSR_MCAUSE:   read_data = mcause_q;
      read_address == CSR_MTVAL:    read_data = mtval_q;
      read_address inside {CSR_MVENDORID, CSR_MARCHID,
                           CSR_MIMPID, CSR_MHARTID}:
        writeable = 1'b0;
      is_cnt: begin
        read_data = read_address[7] ? cnt_sel[63:32]
                                    : cnt_sel[31:0];
        writeable = read_address[11:8] == 4'hB;
      end
      default: begin
        readable  = 1'b0;
        writeable = 1'b0;
      end
    endcase
  end

  assign interrupt_pending = irq_pend_q;
  assign interrupt_cause   = irq_cause_q;
  assign mret_vector       = mepc_rd;
  assign trap_vector = {tvec_base_q, 2'b00}
    + ((tvec_mode_q == csr_pkg::VECTORED && irq_pend_q)
       ? {26'b0, irq_cause_q, 2'b00} : 32'h0);

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: counters, trap/mret,
// interrupt arbitration and mtvec legalisation.
module tb_csr_file;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] read_address;
  logic        write_enable;
  logic [11:0] write_address;
  logic [31:0] write_data;
  logic        retired, traped, mret, interupt;
  logic [31:0] ecp, trap_value;
  logic [3:0]  trap_cause;
  logic        irq_external, irq_timer, irq_software;
  logic [3:0]  hpm_event;

  logic [31:0] read_data, trap_vector, mret_vector;
  logic        readable, writeable, interrupt_pending;
  logic [3:0]  interrupt_cause;
  logic [31:0] read_data_2, trap_vector_2, mret_vector_2;
  logic        readable_2, writeable_2, interrupt_pending_2;
  logic [3:0]  interrupt_cause_2;

  int n_cmp = 0;
  int n_err = 0;

  always #50 clk = ~clk;

  csr_file #(
    .HPM_COUNTERS (4),
    .COUNTER_WIDTH(40),
    .VECTORED     (1'b1),
    .MTVEC_RESET  (32'h0000_0400)
  ) dut (
    .clk(clk), .reset(reset),
    .read_address(read_address), .read_data(read_data),
    .readable(readable), .writeable(writeable),
    .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .retired(retired),
    .traped(traped), .mret(mret), .ecp(ecp),
    .trap_cause(trap_cause), .interupt(interupt),
    .trap_value(trap_value), .irq_external(irq_external),
    .irq_timer(irq_timer), .irq_software(irq_software),
    .hpm_event(hpm_event),
    .interrupt_pending(interrupt_pending),
    .interrupt_cause(interrupt_cause),
    .trap_vector(trap_vector), .mret_vector(mret_vector)
  );

  csr_file #(
    .VECTORED(1'b0)
  ) dut2 (
    .clk(clk), .reset(reset),
    .read_address(read_address), .read_data(read_data_2),
    .readable(readable_2), .writeable(writeable_2),
    .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .retired(retired),
    .traped(traped), .mret(mret), .ecp(ecp),
    .trap_cause(trap_cause), .interupt(interupt),
    .trap_value(trap_value), .irq_external(irq_external),
    .irq_timer(irq_timer), .irq_software(irq_software),
    .hpm_event(hpm_event),
    .interrupt_pending(interrupt_pending_2),
    .interrupt_cause(interrupt_cause_2),
    .trap_vector(trap_vector_2), .mret_vector(mret_vector_2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag,
                        input logic [11:0] a,
                        input logic [31:0] exp);
    read_address = a;
    #1;
    chk(tag, read_data, exp);
  endtask

  task automatic chk_fl(input string tag,
                        input logic [11:0] a,
                        input logic rd_ok,
                        input logic wr_ok);
    read_address = a;
    #1;
    chk({tag, "_rdbl"}, {31'b0, readable}, {31'b0, rd_ok});
    chk({tag, "_wrbl"}, {31'b0, writeable}, {31'b0, wr_ok});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    write_enable  = 1'b1;
    write_address = a;
    write_data    = d;
    tick();
    write_enable  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    read_address = '0;
    write_enable = 1'b0;
    write_address = '0;
    write_data = '0;
    {retired, traped, mret, interupt} = '0;
    ecp = '0;
    trap_value = '0;
    trap_cause = '0;
    {irq_external, irq_timer, irq_software} = '0;
    hpm_event = '0;
    repeat (2) tick();
    reset = 1'b0;

    chk_rd("rst_mcycle", CSR_MCYCLE, 32'h0);
    chk_rd("rst_mtvec", CSR_MTVEC, 32'h400);
    chk("rst_pend", {31'b0, interrupt_pending}, 32'h0);
    chk("rst_cause", {28'b0, interrupt_cause}, 32'h0);
    chk("rst_tvec", trap_vector, 32'h400);
    chk("rst_mretv", mret_vector, 32'h0);

    repeat (10) tick();
    chk_rd("cnt_mcycle10", CSR_MCYCLE, 32'd10);
    chk_rd("cnt_minstret0", CSR_MINSTRET, 32'd0);
    chk_rd("cnt_cycle10", CSR_CYCLE, 32'd10);

    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk_rd("midrst_mcycle", CSR_MCYCLE, 32'h0);
    chk_rd("midrst_mcycleh", CSR_MCYCLEH, 32'h0);
    tick();
    reset = 1'b0;

    wr(CSR_MCOUNTINHIBIT, 32'h1);
    chk_rd("inh_wrcycle", CSR_MCYCLE, 32'd1);
    chk_rd("inh_reg", CSR_MCOUNTINHIBIT, 32'h1);
    repeat (3) tick();
    chk_rd("inh_frozen", CSR_MCYCLE, 32'd1);

    wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
    chk_rd("hi_trunc", CSR_MCYCLEH, 32'h0000_00FF);
    chk_rd("hi_lo_hold", CSR_MCYCLE, 32'd1);

    wr(CSR_MCYCLEH, 32'h12);
    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(CSR_MCOUNTINHIBIT, 32'h0);
    chk_rd("pre_carry_lo", CSR_MCYCLE, 32'hFFFF_FFFF);
    chk_rd("pre_carry_hi", CSR_MCYCLEH, 32'h12);
    tick();
    chk_rd("carry_lo", CSR_MCYCLE, 32'h0);
    chk_rd("carry_hi", CSR_MCYCLEH, 32'h13);
    wr(CSR_MCYCLEH, 32'h5);
    chk_rd("wrhi_hi", CSR_MCYCLEH, 32'h5);
    chk_rd("wrhi_lo_hold", CSR_MCYCLE, 32'h0);

    repeat (5) begin
      hpm_event = 4'b0001;
      tick();
      hpm_event = 4'b0000;
      tick();
    end
    repeat (3) begin
      retired = 1'b1;
      tick();
      retired = 1'b0;
      tick();
    end
    chk_rd("hpm3_m", CSR_MHPMCOUNTER3, 32'd5);
    chk_rd("hpm3_u", CSR_HPMCOUNTER3, 32'd5);
    chk_rd("hpm4_idle", 12'hB04, 32'd0);
    chk_rd("minstret3", CSR_MINSTRET, 32'd3);
    chk_rd("instret3", CSR_INSTRET, 32'd3);
    chk_rd("hpm31_val", 12'hB1F, 32'h0);
    chk_fl("hpm31_m", 12'hB1F, 1'b1, 1'b1);
    chk_fl("hpm31_u", 12'hC1F, 1'b1, 1'b0);
    chk_fl("cycle_u", CSR_CYCLE, 1'b1, 1'b0);
    chk_fl("unmapped", 12'h7C0, 1'b0, 1'b0);
    chk_rd("unmapped_val", 12'h7C0, 32'h0);

    wr(CSR_MSCRATCH, 32'hCAFE_BABE);
    chk_rd("mscratch", CSR_MSCRATCH, 32'hCAFE_BABE);
    wr(CSR_MEPC, 32'h103);
    chk_rd("mepc_align", CSR_MEPC, 32'h100);

    wr(CSR_MSTATUS, 32'h8);
    chk_rd("mstatus_mie", CSR_MSTATUS, 32'h1808);
    ecp = 32'h100;
    trap_cause = 4'd2;
    interupt = 1'b0;
    trap_value = 32'hDEAD;
    traped = 1'b1;
    tick();
    traped = 1'b0;
    chk_rd("trap_mepc", CSR_MEPC, 32'h100);
    chk_rd("trap_mcause", CSR_MCAUSE, 32'h2);
    chk_rd("trap_mtval", CSR_MTVAL, 32'hDEAD);
    chk_rd("trap_mstatus", CSR_MSTATUS, 32'h1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk_rd("mret_mstatus", CSR_MSTATUS, 32'h1888);
    chk("mret_vec", mret_vector, 32'h100);

    wr(CSR_MTVEC, 32'h201);
    wr(CSR_MIE, 32'h888);
    chk_rd("vec_mtvec", CSR_MTVEC, 32'h201);
    chk_rd("vec_mie", CSR_MIE, 32'h888);
    irq_timer = 1'b1;
    irq_external = 1'b1;
    tick();
    chk("irq_lat1", {31'b0, interrupt_pending}, 32'h0);
    chk_rd("irq_mip", CSR_MIP, 32'h880);
    tick();
    chk("irq_pend", {31'b0, interrupt_pending}, 32'h1);
    chk("irq_cause_mei", {28'b0, interrupt_cause}, 32'd11);
    chk("irq_tvec_mei", trap_vector, 32'h22C);
    ecp = 32'h200;
    trap_cause = 4'd11;
    interupt = 1'b1;
    traped = 1'b1;
    tick();
    traped = 1'b0;
    interupt = 1'b0;
    chk("irq_trap_edge", {31'b0, interrupt_pending}, 32'h1);
    chk_rd("irq_mcause", CSR_MCAUSE, 32'h8000_000B);
    tick();
    chk("irq_drop", {31'b0, interrupt_pending}, 32'h0);
    chk("irq_cause_hold", {28'b0, interrupt_cause}, 32'd11);
    chk("irq_tvec_base", trap_vector, 32'h200);

    irq_external = 1'b0;
    irq_software = 1'b1;
    wr(CSR_MSTATUS, 32'h8);
    tick();
    chk("prio_msi", {28'b0, interrupt_cause}, 32'd3);
    chk("prio_tvec_msi", trap_vector, 32'h20C);
    irq_software = 1'b0;
    repeat (2) tick();
    chk("prio_mti", {28'b0, interrupt_cause}, 32'd7);
    chk("prio_tvec_mti", trap_vector, 32'h21C);
    wr(CSR_MIP, 32'h0);
    chk_rd("mip_wr_noeff", CSR_MIP, 32'h080);

    wr(CSR_MTVEC, 32'h302);
    chk_rd("legal_mode2", CSR_MTVEC, 32'h300);
    wr(CSR_MTVEC, 32'h301);
    chk_rd("legal_v1", CSR_MTVEC, 32'h301);
    chk("legal_v0", read_data_2, 32'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
